// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM: mode encodings and the
// duty clamp used by every compare slice.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwmMode_e;

  // Wide enough to hold P+1 for any counter width up to 32 bits without overflow.
  localparam int CLAMP_W = 33;

  // Saturates a duty value at P+1. The counter never exceeds P in either mode
  // (edge counts 0..P, center peaks at P), so any duty above P already means
  // "always active". Clamping keeps the compare operands bounded and makes
  // that saturation explicit.
  function automatic logic [CLAMP_W-1:0] dutyClamp(input logic [CLAMP_W-1:0] duty,
                                                   input logic [CLAMP_W-1:0] period);
    logic [CLAMP_W-1:0] limit;
    limit = period + 1'b1;
    return (duty > limit) ? limit : duty;
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Control/status bundle between the register block and the PWM generator.
// The master drives configuration, the slave (pwm_multi) returns the pins
// and status flags.
interface pwm_multi_if #(
  parameter int CH = 4,
  parameter int CW = 8
);

  logic             en;
  logic             load;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] duty;
  logic             mode;
  logic [CH-1:0]    pol;
  logic [CH-1:0]    pwm_out;
  logic             period_end;
  logic             pending;

  modport master (
    output en, load, period, duty, mode, pol,
    input  pwm_out, period_end, pending
  );

  modport slave (
    input  en, load, period, duty, mode, pol,
    output pwm_out, period_end, pending
  );

endinterface

// File: rtl/pwm_multi_timebase.sv
// Shared timebase: the period counter with its up/down direction, the
// period boundary detect, and the pending/active double-buffered
// configuration. Active values only change at a boundary (or while
// disabled), so the compare slices never see a mid-period change.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CH = 4,
  parameter int CW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CW-1:0]    period_i,
  input  logic [CH*CW-1:0] duty_i,
  input  pwmMode_e         mode_i,
  output logic [CW-1:0]    cnt_o,
  output logic [CW-1:0]    period_o,
  output logic [CH*CW-1:0] duty_o,
  output logic             periodEnd_o,
  output logic             pending_o
);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dirDown_q, dirDown_d;
  logic             boundary;

  logic [CW-1:0]    activePeriod_q;
  logic [CH*CW-1:0] activeDuty_q;
  pwmMode_e         activeMode_q;

  logic [CW-1:0]    pendPeriod_q;
  logic [CH*CW-1:0] pendDuty_q;
  pwmMode_e         pendMode_q;
  logic             pending_q;
  logic             periodEnd_q;

  // Next counter position; a boundary is any cycle whose successor count is 0.
  always_comb begin
    cnt_d     = cnt_q;
    dirDown_d = dirDown_q;
    if (activeMode_q == MODE_EDGE) begin
      if (cnt_q >= activePeriod_q) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (activePeriod_q == '0) begin
      cnt_d = '0;
    end else if (!dirDown_q) begin
      if (cnt_q >= activePeriod_q) begin
        cnt_d     = activePeriod_q - 1'b1;
        dirDown_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    boundary = (cnt_d == '0);
  end

  // Counter advance plus the shadow/active register transfer at period boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      dirDown_q      <= 1'b0;
      activePeriod_q <= '0;
      activeDuty_q   <= '0;
      activeMode_q   <= MODE_EDGE;
      pendPeriod_q   <= '0;
      pendDuty_q     <= '0;
      pendMode_q     <= MODE_EDGE;
      pending_q      <= 1'b0;
      periodEnd_q    <= 1'b0;
    end else begin
      periodEnd_q <= en_i & boundary;
      if (!en_i || boundary) begin
        cnt_q     <= '0;
        dirDown_q <= 1'b0;
        pending_q <= 1'b0;
        if (load_i) begin
          activePeriod_q <= period_i;
          activeDuty_q   <= duty_i;
          activeMode_q   <= mode_i;
        end else if (pending_q) begin
          activePeriod_q <= pendPeriod_q;
          activeDuty_q   <= pendDuty_q;
          activeMode_q   <= pendMode_q;
        end
      end else begin
        cnt_q     <= cnt_d;
        dirDown_q <= dirDown_d;
        if (load_i) begin
          pendPeriod_q <= period_i;
          pendDuty_q   <= duty_i;
          pendMode_q   <= mode_i;
          pending_q    <= 1'b1;
        end
      end
    end
  end

  assign cnt_o       = cnt_q;
  assign period_o    = activePeriod_q;
  assign duty_o      = activeDuty_q;
  assign periodEnd_o = periodEnd_q;
  assign pending_o   = pending_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared timebase feeding CH compare
// slices. Each slice registers its active level; polarity is applied after
// the register so a polarity change shows up at once and the reset level
// equals pol without needing a data-dependent async reset value.
// CW must not exceed 32 (compare is done at CLAMP_W bits).
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH = 4,
  parameter int CW = 8
) (
  input  logic  clk,
  input  logic  rst,
  pwm_multi_if.slave bus
);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] duty;
  logic [CH-1:0]    active_d, active_q;

  pwm_timebase #(
    .CH(CH),
    .CW(CW)
  ) uTimebase (
    .clk        (clk),
    .rst        (rst),
    .en_i       (bus.en),
    .load_i     (bus.load),
    .period_i   (bus.period),
    .duty_i     (bus.duty),
    .mode_i     (pwmMode_e'(bus.mode)),
    .cnt_o      (cnt),
    .period_o   (period),
    .duty_o     (duty),
    .periodEnd_o(bus.period_end),
    .pending_o  (bus.pending)
  );

  for (genvar i = 0; i < CH; i++) begin : gSlice
    logic [CLAMP_W-1:0] dutyLimit;
    assign dutyLimit   = dutyClamp(CLAMP_W'(duty[i*CW +: CW]), CLAMP_W'(period));
    assign active_d[i] = bus.en && (CLAMP_W'(cnt) < dutyLimit);
  end

  // Register the per-channel active levels; outputs lag the counter by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
    end else begin
      active_q <= active_d;
    end
  end

  assign bus.pwm_out = active_q ^ bus.pol;

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi. A reference model tracks each period as a
// position index within a period of known length and derives the counter
// value from that index, then compares outputs once per cycle.
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int CH = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;

  pwm_multi_if #(.CH(CH), .CW(CW)) bus ();

  pwm_multi #(.CH(CH), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: active config, pending config, position within period.
  int          mP, mMode, mD[CH];
  int          pP, pMode, pD[CH];
  logic        pValid;
  int          mK;
  logic [CH-1:0] mBits;
  logic        mPe;

  function automatic int periodLen(input int p, input int m);
    if (p == 0) return 1;
    return (m != 0) ? 2 * p : p + 1;
  endfunction

  function automatic int cntAt(input int k, input int p, input int m);
    if (m != 0 && k > p) return 2 * p - k;
    return k;
  endfunction

  function automatic void modelReset();
    mP = 0; mMode = 0; pP = 0; pMode = 0; pValid = 1'b0;
    mK = 0; mBits = '0; mPe = 1'b0;
    for (int i = 0; i < CH; i++) begin
      mD[i] = 0;
      pD[i] = 0;
    end
  endfunction

  // Advance DUT and model by one clock; returns at the following negedge.
  task automatic tick();
    int  cnt;
    logic bnd;
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      cnt = cntAt(mK, mP, mMode);
      for (int i = 0; i < CH; i++) mBits[i] = bus.en && (cnt < mD[i]);
      bnd = bus.en && (mK == periodLen(mP, mMode) - 1);
      mPe = bnd;
      if (!bus.en || bnd) begin
        mK = 0;
        if (bus.load) begin
          mP = int'(bus.period); mMode = int'(bus.mode);
          for (int i = 0; i < CH; i++) mD[i] = int'(bus.duty[i*CW +: CW]);
        end else if (pValid) begin
          mP = pP; mMode = pMode;
          for (int i = 0; i < CH; i++) mD[i] = pD[i];
        end
        pValid = 1'b0;
      end else begin
        mK++;
        if (bus.load) begin
          pP = int'(bus.period); pMode = int'(bus.mode);
          for (int i = 0; i < CH; i++) pD[i] = int'(bus.duty[i*CW +: CW]);
          pValid = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  // One-cycle load pulse with the given configuration.
  task automatic applyStimulus(input int p, input logic [CH*CW-1:0] d, input logic m);
    bus.period = CW'(p);
    bus.duty   = d;
    bus.mode   = m;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.load = 1'b0; bus.period = '0; bus.duty = '0;
    bus.mode = 1'b0; bus.pol = 4'b1010;
    modelReset();
    #12;
    assertCount++;
    if (bus.pwm_out !== 4'b1010 || bus.period_end !== 1'b0 || bus.pending !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got pwm=%b pe=%b pend=%b, want pwm=1010 pe=0 pend=0",
               bus.pwm_out, bus.period_end, bus.pending);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.pol = 4'b0000;
  endtask

  task automatic test_edge();
    int hi[CH];
    int peCount, firstPe;
    for (int i = 0; i < CH; i++) hi[i] = 0;
    peCount = 0; firstPe = -1;
    bus.en = 1'b0;
    applyStimulus(99, {8'd200, 8'd100, 8'd0, 8'd25}, MODE_EDGE);
    bus.en = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      assertCount++;
      if (bus.pwm_out !== (mBits ^ bus.pol) || bus.period_end !== mPe || bus.pending !== pValid) begin
        failCount++;
        $display("[TB] FAIL edge_run cyc=%0d: got pwm=%b pe=%b pend=%b, want pwm=%b pe=%b pend=%b",
                 c, bus.pwm_out, bus.period_end, bus.pending, mBits ^ bus.pol, mPe, pValid);
      end
      for (int i = 0; i < CH; i++) hi[i] += int'(bus.pwm_out[i]);
      if (bus.period_end === 1'b1) begin
        peCount++;
        if (firstPe < 0) firstPe = c;
      end
    end
    assertCount++;
    if (hi[0] != 50 || hi[1] != 0 || hi[2] != 200 || hi[3] != 200) begin
      failCount++;
      $display("[TB] FAIL edge_duty_counts: got %0d/%0d/%0d/%0d, want 50/0/200/200",
               hi[0], hi[1], hi[2], hi[3]);
    end
    assertCount++;
    if (peCount != 2 || firstPe != 100) begin
      failCount++;
      $display("[TB] FAIL edge_period_end: got count=%0d first=%0d, want count=2 first=100",
               peCount, firstPe);
    end
  endtask

  task automatic test_center();
    int hi0, peCount;
    hi0 = 0; peCount = 0;
    bus.en = 1'b0;
    tick();
    applyStimulus(10, {8'd0, 8'd0, 8'd0, 8'd4}, MODE_CENTER);
    bus.en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      assertCount++;
      if (bus.pwm_out !== (mBits ^ bus.pol) || bus.period_end !== mPe || bus.pending !== pValid) begin
        failCount++;
        $display("[TB] FAIL center_run cyc=%0d: got pwm=%b pe=%b pend=%b, want pwm=%b pe=%b pend=%b",
                 c, bus.pwm_out, bus.period_end, bus.pending, mBits ^ bus.pol, mPe, pValid);
      end
      hi0 += int'(bus.pwm_out[0]);
      if (bus.period_end === 1'b1) peCount++;
    end
    assertCount++;
    if (hi0 != 14 || peCount != 2) begin
      failCount++;
      $display("[TB] FAIL center_counts: got high=%0d pe=%0d, want high=14 pe=2", hi0, peCount);
    end
  endtask

  task automatic test_shadow();
    int  hi0;
    logic seen, pendSeen;
    bus.en = 1'b0;
    tick();
    applyStimulus(9, {8'd0, 8'd0, 8'd0, 8'd3}, MODE_EDGE);
    bus.en = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    bus.duty[7:0] = 8'd7;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    assertCount++;
    if (bus.pending !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL shadow_pending_set: got %b, want 1", bus.pending);
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      assertCount++;
      if (bus.pwm_out !== (mBits ^ bus.pol) || bus.period_end !== mPe || bus.pending !== pValid) begin
        failCount++;
        $display("[TB] FAIL shadow_hold cyc=%0d: got pwm=%b pe=%b pend=%b, want pwm=%b pe=%b pend=%b",
                 c, bus.pwm_out, bus.period_end, bus.pending, mBits ^ bus.pol, mPe, pValid);
      end
      if (bus.period_end === 1'b1) seen = 1'b1;
    end
    assertCount++;
    if (!seen || bus.pending !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL shadow_apply: got boundary_seen=%b pend=%b, want 1 and 0", seen, bus.pending);
    end
    hi0 = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      hi0 += int'(bus.pwm_out[0]);
    end
    assertCount++;
    if (hi0 != 7) begin
      failCount++;
      $display("[TB] FAIL shadow_new_duty: got high=%0d, want 7", hi0);
    end
    for (int c = 0; c < 20 && mK != periodLen(mP, mMode) - 1; c++) tick();
    bus.duty[7:0] = 8'd2;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    hi0 = 0;
    pendSeen = bus.pending;
    for (int c = 0; c < 10; c++) begin
      tick();
      assertCount++;
      if (bus.pwm_out !== (mBits ^ bus.pol) || bus.period_end !== mPe || bus.pending !== pValid) begin
        failCount++;
        $display("[TB] FAIL boundary_load_run cyc=%0d: got pwm=%b pe=%b pend=%b, want pwm=%b pe=%b pend=%b",
                 c, bus.pwm_out, bus.period_end, bus.pending, mBits ^ bus.pol, mPe, pValid);
      end
      hi0 += int'(bus.pwm_out[0]);
      if (bus.pending !== 1'b0) pendSeen = 1'b1;
    end
    assertCount++;
    if (hi0 != 2 || pendSeen !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL boundary_load: got high=%0d pend_seen=%b, want high=2 pend_seen=0", hi0, pendSeen);
    end
  endtask

  task automatic test_polarity_enable();
    int firstPe;
    bus.pol = 4'b0010;
    #1;
    assertCount++;
    if (bus.pwm_out !== (mBits ^ 4'b0010)) begin
      failCount++;
      $display("[TB] FAIL pol_immediate: got %b, want %b", bus.pwm_out, mBits ^ 4'b0010);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      assertCount++;
      if (bus.pwm_out !== (mBits ^ bus.pol) || bus.period_end !== mPe || bus.pending !== pValid) begin
        failCount++;
        $display("[TB] FAIL pol_run cyc=%0d: got pwm=%b pe=%b pend=%b, want pwm=%b pe=%b pend=%b",
                 c, bus.pwm_out, bus.period_end, bus.pending, mBits ^ bus.pol, mPe, pValid);
      end
    end
    bus.en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      assertCount++;
      if (bus.pwm_out !== 4'b0010 || bus.period_end !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL disabled_outputs cyc=%0d: got pwm=%b pe=%b, want pwm=0010 pe=0",
                 c, bus.pwm_out, bus.period_end);
      end
    end
    bus.en = 1'b1;
    firstPe = -1;
    for (int c = 1; c <= 30 && firstPe < 0; c++) begin
      tick();
      if (bus.period_end === 1'b1) firstPe = c;
    end
    assertCount++;
    if (firstPe != 10) begin
      failCount++;
      $display("[TB] FAIL enable_first_period_end: got cycle %0d, want 10", firstPe);
    end
  endtask

  task automatic test_async_reset();
    bus.pol = 4'b0101;
    for (int c = 0; c < 3; c++) tick();
    bus.duty[7:0] = 8'd5;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    assertCount++;
    if (bus.pending !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_pending_before: got %b, want 1", bus.pending);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    modelReset();
    #1;
    assertCount++;
    if (bus.pwm_out !== 4'b0101 || bus.pending !== 1'b0 || bus.period_end !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got pwm=%b pend=%b pe=%b, want pwm=0101 pend=0 pe=0",
               bus.pwm_out, bus.pending, bus.period_end);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      assertCount++;
      if (bus.pwm_out !== 4'b0101 || bus.pwm_out !== (mBits ^ bus.pol) ||
          bus.period_end !== mPe || bus.pending !== pValid) begin
        failCount++;
        $display("[TB] FAIL after_reset cyc=%0d: got pwm=%b pe=%b pend=%b, want pwm=0101 pe=%b pend=%b",
                 c, bus.pwm_out, bus.period_end, bus.pending, mPe, pValid);
      end
    end
  endtask

  task automatic test_p0();
    int peCount, hi0, hi1;
    peCount = 0; hi0 = 0; hi1 = 0;
    bus.en = 1'b0;
    bus.pol = 4'b0000;
    applyStimulus(0, {8'd0, 8'd5, 8'd1, 8'd0}, MODE_EDGE);
    bus.en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      assertCount++;
      if (bus.pwm_out !== (mBits ^ bus.pol) || bus.period_end !== mPe || bus.pending !== pValid) begin
        failCount++;
        $display("[TB] FAIL p0_run cyc=%0d: got pwm=%b pe=%b pend=%b, want pwm=%b pe=%b pend=%b",
                 c, bus.pwm_out, bus.period_end, bus.pending, mBits ^ bus.pol, mPe, pValid);
      end
      hi0 += int'(bus.pwm_out[0]);
      hi1 += int'(bus.pwm_out[1]);
      if (bus.period_end === 1'b1) peCount++;
    end
    assertCount++;
    if (hi0 != 0 || hi1 != 10 || peCount != 10) begin
      failCount++;
      $display("[TB] FAIL p0_counts: got ch0=%0d ch1=%0d pe=%0d, want 0/10/10", hi0, hi1, peCount);
    end
  endtask

  task automatic test_random();
    logic [CH*CW-1:0] d;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < CH; i++) d[i*CW +: CW] = CW'($urandom_range(0, 15));
        bus.period = CW'($urandom_range(0, 12));
        bus.duty   = d;
        bus.mode   = 1'($urandom_range(0, 1));
        bus.load   = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 59) == 0) bus.pol = CH'($urandom_range(0, 15));
      tick();
      assertCount++;
      if (bus.pwm_out !== (mBits ^ bus.pol) || bus.period_end !== mPe || bus.pending !== pValid) begin
        failCount++;
        $display("[TB] FAIL random_run cyc=%0d: got pwm=%b pe=%b pend=%b, want pwm=%b pe=%b pend=%b",
                 c, bus.pwm_out, bus.period_end, bus.pending, mBits ^ bus.pol, mPe, pValid);
      end
    end
    bus.load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_shadow();
    test_polarity_enable();
    test_async_reset();
    test_p0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Guard against a hung simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
